// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption engine (AES-128/192/256).
// The key is expanded one 32-bit word per cycle into a local round-key store,
// then one cipher round runs per cycle. A held expanded key can be reused for
// later blocks with the same key length.
//
// state  | meaning
// IDLE   | waiting for a block; in_ready high
// KEYEXP | producing round-key word w[widx], one per cycle
// ROUND  | applying round rnd (0 = initial AddRoundKey, Nr = final round)
// DONE   | result held on out_data/out_err until the sink accepts it
module aes_iter_cipher #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic [1:0]            key_len,
  input  logic                  key_reuse,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic                  out_err
);

  localparam int MAX_NR = MAX_NK + 6;
  localparam int DEPTH  = 4 * (MAX_NR + 1);
  localparam int IW     = $clog2(DEPTH);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KEYEXP = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) o[8*b +: 8] = sbox(s[8*b +: 8]);
    return o;
  endfunction

  // Byte (row r, column c) sits at index r+4c, byte 0 in the MSBs.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      2'd0:    return 4'd4;
      2'd1:    return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  state_t          r_state;
  logic [31:0]     r_w [DEPTH];
  logic [127:0]    r_st;
  logic [1:0]      r_len;
  logic [1:0]      r_stored_len;
  logic            r_key_ok;
  logic [IW-1:0]   r_widx;
  logic [3:0]      r_kcnt;
  logic [7:0]      r_rcon;
  logic [3:0]      r_rnd;
  logic            r_out_valid;
  logic [127:0]    r_out_data;
  logic            r_out_err;

  logic            w_accept;
  logic            w_in_bad;
  logic            w_reuse_hit;
  logic [3:0]      w_nk;
  logic [3:0]      w_nr;
  logic [IW-1:0]   w_last;
  logic [31:0]     w_prev;
  logic [31:0]     w_old;
  logic [31:0]     w_t;
  logic [31:0]     w_new;
  logic [IW-1:0]   w_rk_base;
  logic [127:0]    w_rk;
  logic [127:0]    w_sr;
  logic [127:0]    w_mc;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  assign w_accept    = in_valid && in_ready;
  assign w_in_bad    = (key_len == 2'd3) || (int'(nk_of(key_len)) > MAX_NK);
  assign w_reuse_hit = key_reuse && r_key_ok && (key_len == r_stored_len);

  // Key-schedule word generation for the word currently indexed by r_widx.
  always_comb begin
    w_nk   = nk_of(r_len);
    w_nr   = w_nk + 4'd6;
    w_last = IW'({2'b00, w_nr, 2'b00} + 8'd3);
    w_prev = r_w[r_widx - IW'(1)];
    w_old  = r_w[r_widx - IW'(w_nk)];
    if (r_kcnt == 4'd0)
      w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if ((w_nk == 4'd8) && (r_kcnt == 4'd4))
      w_t = sub_word(w_prev);
    else
      w_t = w_prev;
    w_new = w_old ^ w_t;
  end

  // Round-key fetch and round datapath.
  always_comb begin
    w_rk_base = IW'({r_rnd, 2'b00});
    w_rk = {r_w[w_rk_base], r_w[w_rk_base + IW'(1)],
            r_w[w_rk_base + IW'(2)], r_w[w_rk_base + IW'(3)]};
    w_sr = shift_rows(sub_bytes(r_st));
    w_mc = mix_columns(w_sr);
  end

  // Round-key store: seeded with the cipher key on accept, then one word per KEYEXP cycle.
  always_ff @(posedge clk) begin
    if (w_accept && !w_in_bad && !w_reuse_hit) begin
      for (int j = 0; j < MAX_NK; j++)
        if (j < int'(nk_of(key_len)))
          r_w[j] <= key[32*(MAX_NK-j)-1 -: 32];
    end else if (r_state == S_KEYEXP) begin
      r_w[r_widx] <= w_new;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_st         <= '0;
      r_len        <= '0;
      r_stored_len <= '0;
      r_key_ok     <= 1'b0;
      r_widx       <= '0;
      r_kcnt       <= '0;
      r_rcon       <= 8'h01;
      r_rnd        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_st  <= in_data;
            r_len <= key_len;
            r_rnd <= '0;
            if (w_in_bad) begin
              // Error result is raised on the following edge, like any other result.
              r_out_err  <= 1'b1;
              r_out_data <= '0;
              r_key_ok   <= 1'b0;
              r_state    <= S_DONE;
            end else if (w_reuse_hit) begin
              r_state <= S_ROUND;
            end else begin
              r_widx       <= IW'(nk_of(key_len));
              r_kcnt       <= '0;
              r_rcon       <= 8'h01;
              r_key_ok     <= 1'b0;
              r_stored_len <= key_len;
              r_state      <= S_KEYEXP;
            end
          end
        end
        S_KEYEXP: begin
          r_widx <= r_widx + IW'(1);
          r_kcnt <= (r_kcnt == w_nk - 4'd1) ? 4'd0 : r_kcnt + 4'd1;
          if (r_kcnt == 4'd0) r_rcon <= xtime(r_rcon);
          if (r_widx == w_last) begin
            r_key_ok <= 1'b1;
            r_rnd    <= '0;
            r_state  <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == 4'd0) begin
            r_st <= r_st ^ w_rk;
          end else if (r_rnd < w_nr) begin
            r_st <= w_mc ^ w_rk;
          end else begin
            r_out_data  <= w_sr ^ w_rk;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
